// File: rtl/lsu_arb_pkg.sv
// Shared encodings and helpers for the IF/EX load-store arbiter.
// Holds the FSM state, the request owner, and the EX strobe normalisation.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } own_t;

    localparam int          CNT_W   = 4;
    localparam logic [3:0]  CNT_SAT = 4'd15;

    // A combined read+write request is issued as a pure write.
    function automatic logic [1:0] ex_strobes(input logic ren, input logic wen);
        return {ren & ~wen, wen};
    endfunction

endpackage

// File: rtl/lsu_arb_starve_cnt.sv
// Saturating count of EX grants taken while IF was waiting.
// ge_max tells the arbiter that IF must win the next contested grant.
module arb_starve_cnt
    import lsu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic ge_max
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign ge_max = (cnt_q >= 4'(STARVE_MAX));

endmodule

// File: rtl/lsu_arb.sv
// Arbitrates IF fetches and EX loads/stores onto one bus port with a
// single outstanding transaction; EX has priority unless IF is starving.
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hs_if4arb_val,
    output logic          o_arb4if_rdy,
    input  logic [AW-1:0] i_if_adr,
    output logic          o_if_rsp_val,
    output logic [AW-1:0] o_if_rdata,
    input  logic          hs_ex4mem_val,
    output logic          hs_mem4ex_rdy,
    input  logic [AW-1:0] i_mem_adr,
    input  logic [AW-1:0] i_mem_d,
    input  logic          i_mem_ren,
    input  logic          i_mem_wen,
    output logic          o_ex_rsp_val,
    output logic [AW-1:0] o_ex_rdata,
    output logic          o_bus_val,
    input  logic          i_bus_rdy,
    output logic [AW-1:0] o_bus_adr,
    output logic [AW-1:0] o_bus_d,
    output logic          o_bus_ren,
    output logic          o_bus_wen,
    input  logic          i_bus_rsp_val,
    input  logic [AW-1:0] i_bus_rdata
);

    state_t        state_q, state_nxt;
    own_t          own_p0;
    logic [AW-1:0] adr_p0, d_p0;
    logic          ren_p0, wen_p0;
    logic          ge_max, in_idle, grant_ex, grant_if, acc_if, acc_ex;
    logic [1:0]    ex_rw;

    // Rdy is held low while reset is asserted so every output reads 0.
    always_comb begin
        in_idle  = (state_q == ST_IDLE) && rst_n;
        grant_ex = hs_ex4mem_val && !(hs_if4arb_val && ge_max);
        grant_if = hs_if4arb_val && !grant_ex;
        acc_if   = in_idle && grant_if;
        acc_ex   = in_idle && grant_ex;
        ex_rw    = ex_strobes(i_mem_ren, i_mem_wen);
    end

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (acc_ex && hs_if4arb_val),
        .clr    (acc_if),
        .ge_max (ge_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (acc_if || acc_ex) state_nxt = ST_REQ;
            ST_REQ:  if (i_bus_rdy)        state_nxt = ST_RSP;
            ST_RSP:  if (i_bus_rsp_val)    state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Accept stage: capture the granted request for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_p0 <= OWN_IF;
            adr_p0 <= '0;
            d_p0   <= '0;
            ren_p0 <= 1'b0;
            wen_p0 <= 1'b0;
        end else if (acc_ex) begin
            own_p0 <= OWN_EX;
            adr_p0 <= i_mem_adr;
            d_p0   <= i_mem_d;
            ren_p0 <= ex_rw[1];
            wen_p0 <= ex_rw[0];
        end else if (acc_if) begin
            own_p0 <= OWN_IF;
            adr_p0 <= i_if_adr;
            d_p0   <= '0;
            ren_p0 <= 1'b1;
            wen_p0 <= 1'b0;
        end
    end

    always_comb begin
        o_arb4if_rdy  = acc_if;
        hs_mem4ex_rdy = acc_ex;
        o_bus_val     = 1'b0;
        o_bus_adr     = '0;
        o_bus_d       = '0;
        o_bus_ren     = 1'b0;
        o_bus_wen     = 1'b0;
        o_if_rsp_val  = 1'b0;
        o_if_rdata    = '0;
        o_ex_rsp_val  = 1'b0;
        o_ex_rdata    = '0;
        if (state_q == ST_REQ) begin
            o_bus_val = 1'b1;
            o_bus_adr = adr_p0;
            o_bus_d   = d_p0;
            o_bus_ren = ren_p0;
            o_bus_wen = wen_p0;
        end
        // Responses outside RSP are stale or spurious and never reach a requester.
        if ((state_q == ST_RSP) && i_bus_rsp_val) begin
            if (own_p0 == OWN_EX) begin
                o_ex_rsp_val = 1'b1;
                o_ex_rdata   = i_bus_rdata;
            end else begin
                o_if_rsp_val = 1'b1;
                o_if_rdata   = i_bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_arb.sv
// Scoreboard bench for lsu_arb: requests push expected bus fields and
// responses, the bus-side task pops them as the DUT presents them.
module tb_lsu_arb;

    localparam int AW = 32;

    logic          clk, rst_n;
    logic          hs_if4arb_val, o_arb4if_rdy;
    logic [AW-1:0] i_if_adr;
    logic          o_if_rsp_val;
    logic [AW-1:0] o_if_rdata;
    logic          hs_ex4mem_val, hs_mem4ex_rdy;
    logic [AW-1:0] i_mem_adr, i_mem_d;
    logic          i_mem_ren, i_mem_wen;
    logic          o_ex_rsp_val;
    logic [AW-1:0] o_ex_rdata;
    logic          o_bus_val, i_bus_rdy;
    logic [AW-1:0] o_bus_adr, o_bus_d;
    logic          o_bus_ren, o_bus_wen;
    logic          i_bus_rsp_val;
    logic [AW-1:0] i_bus_rdata;

    lsu_arb #(.STARVE_MAX(4), .AW(AW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hs_if4arb_val (hs_if4arb_val),
        .o_arb4if_rdy  (o_arb4if_rdy),
        .i_if_adr      (i_if_adr),
        .o_if_rsp_val  (o_if_rsp_val),
        .o_if_rdata    (o_if_rdata),
        .hs_ex4mem_val (hs_ex4mem_val),
        .hs_mem4ex_rdy (hs_mem4ex_rdy),
        .i_mem_adr     (i_mem_adr),
        .i_mem_d       (i_mem_d),
        .i_mem_ren     (i_mem_ren),
        .i_mem_wen     (i_mem_wen),
        .o_ex_rsp_val  (o_ex_rsp_val),
        .o_ex_rdata    (o_ex_rdata),
        .o_bus_val     (o_bus_val),
        .i_bus_rdy     (i_bus_rdy),
        .o_bus_adr     (o_bus_adr),
        .o_bus_d       (o_bus_d),
        .o_bus_ren     (o_bus_ren),
        .o_bus_wen     (o_bus_wen),
        .i_bus_rsp_val (i_bus_rsp_val),
        .i_bus_rdata   (i_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          own;
        logic [31:0] adr;
        logic [31:0] d;
        logic        ren;
        logic        wen;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hs_if4arb_val = 0; i_if_adr = '0;
        hs_ex4mem_val = 0; i_mem_adr = '0; i_mem_d = '0; i_mem_ren = 0; i_mem_wen = 0;
        i_bus_rdy = 0; i_bus_rsp_val = 0; i_bus_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        sb.delete();
    endtask

    // Drives one request in IDLE, checks who gets rdy, records the expected bus transaction.
    task automatic issue(input bit ifv, input bit exv, input logic [31:0] iadr,
                         input logic [31:0] madr, input logic [31:0] md,
                         input logic mren, input logic mwen, input bit exp_own,
                         input logic [31:0] rdata, input bit keep_if, input bit keep_ex);
        exp_t e;
        hs_if4arb_val = ifv; i_if_adr = iadr;
        hs_ex4mem_val = exv; i_mem_adr = madr; i_mem_d = md; i_mem_ren = mren; i_mem_wen = mwen;
        e.own = exp_own;
        if (exp_own) begin
            e.adr = madr; e.d = md; e.ren = mren & ~mwen; e.wen = mwen;
        end else begin
            e.adr = iadr; e.d = '0; e.ren = 1'b1; e.wen = 1'b0;
        end
        e.rdata = rdata;
        sb.push_back(e);
        #1;
        n_vec++;
        if ({o_arb4if_rdy, hs_mem4ex_rdy} !== (exp_own ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL grant: if_rdy=%b ex_rdy=%b, required owner %s", o_arb4if_rdy,
                     hs_mem4ex_rdy, exp_own ? "EX" : "IF");
        end
        step();
        hs_if4arb_val = keep_if;
        hs_ex4mem_val = keep_ex;
    endtask

    // Plays the bus: stalls rdy for rdy_wait cycles, optionally injects early responses.
    task automatic run_bus(input int rdy_wait, input bit stray);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: empty queue, required one pending transaction");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= rdy_wait; i++) begin
            i_bus_rdy     = (i == rdy_wait);
            i_bus_rsp_val = stray && (i < rdy_wait);
            i_bus_rdata   = 32'hBAD0_0000;
            #1;
            n_vec++;
            if ({o_bus_val, o_bus_adr, o_bus_d, o_bus_ren, o_bus_wen} !== {1'b1, e.adr, e.d, e.ren, e.wen}) begin
                n_err++;
                $display("FAIL bus_req[%0d]: val=%b adr=%h d=%h ren=%b wen=%b, required 1 %h %h %b %b",
                         i, o_bus_val, o_bus_adr, o_bus_d, o_bus_ren, o_bus_wen, e.adr, e.d, e.ren, e.wen);
            end
            n_vec++;
            if ((o_if_rsp_val | o_ex_rsp_val | o_arb4if_rdy | hs_mem4ex_rdy) !== 1'b0 ||
                o_if_rdata !== 0 || o_ex_rdata !== 0) begin
                n_err++;
                $display("FAIL req_quiet[%0d]: if_rsp=%b ex_rsp=%b if_rdy=%b ex_rdy=%b if_rd=%h ex_rd=%h, required all 0",
                         i, o_if_rsp_val, o_ex_rsp_val, o_arb4if_rdy, hs_mem4ex_rdy, o_if_rdata, o_ex_rdata);
            end
            step();
        end
        i_bus_rdy = 0; i_bus_rsp_val = 1; i_bus_rdata = e.rdata;
        #1;
        n_vec++;
        if ({o_if_rsp_val, o_ex_rsp_val} !== (e.own ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL rsp_owner: if_rsp=%b ex_rsp=%b, required owner %s", o_if_rsp_val,
                     o_ex_rsp_val, e.own ? "EX" : "IF");
        end
        n_vec++;
        if ((e.own ? o_ex_rdata : o_if_rdata) !== e.rdata || (e.own ? o_if_rdata : o_ex_rdata) !== 0 ||
            o_bus_val !== 1'b0 || (o_arb4if_rdy | hs_mem4ex_rdy) !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_data: if_rd=%h ex_rd=%h bus_val=%b rdy=%b%b, required rdata %h to owner, rest 0",
                     o_if_rdata, o_ex_rdata, o_bus_val, o_arb4if_rdy, hs_mem4ex_rdy, e.rdata);
        end
        step();
        i_bus_rsp_val = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        hs_if4arb_val = 1; hs_ex4mem_val = 1; i_bus_rdy = 1; i_bus_rsp_val = 1; i_bus_rdata = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if ((o_arb4if_rdy | hs_mem4ex_rdy | o_if_rsp_val | o_ex_rsp_val | o_bus_val | o_bus_ren | o_bus_wen) !== 1'b0 ||
            o_if_rdata !== 0 || o_ex_rdata !== 0 || o_bus_adr !== 0 || o_bus_d !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b%b rsp=%b%b bus_val=%b adr=%h, required all 0",
                     o_arb4if_rdy, hs_mem4ex_rdy, o_if_rsp_val, o_ex_rsp_val, o_bus_val, o_bus_adr);
        end
        step();
        idle_inputs();
        rst_n = 1;
        step();
    endtask

    task automatic test_ex_read();
        issue(0, 1, 32'h0, 32'h100, 32'h0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
        run_bus(0, 0);
    endtask

    task automatic test_arb_order();
        do_reset();
        issue(1, 1, 32'h200, 32'h300, 32'h55, 1, 0, 1, 32'h1111_1111, 1, 0);
        run_bus(0, 0);
        issue(1, 0, 32'h200, 32'h300, 32'h55, 1, 0, 0, 32'h2222_2222, 0, 0);
        run_bus(0, 0);
    endtask

    task automatic test_starve();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            issue(1, 1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'(k), 1, 0,
                  (k % 5 == 4) ? 1'b0 : 1'b1, 32'hA000 + 32'(k), k < 9, k < 9);
            run_bus(0, 0);
        end
    endtask

    task automatic test_write_stall();
        issue(0, 1, 32'h0, 32'h40, 32'h1234, 1, 1, 1, 32'h0, 0, 0);
        run_bus(3, 0);
    endtask

    task automatic test_no_strobe();
        issue(0, 1, 32'h0, 32'h80, 32'h77, 0, 0, 1, 32'h5, 0, 0);
        run_bus(1, 0);
    endtask

    task automatic test_stray_rsp();
        i_bus_rsp_val = 1; i_bus_rdata = 32'h1357_9BDF;
        #1;
        n_vec++;
        if ((o_if_rsp_val | o_ex_rsp_val | o_bus_val) !== 1'b0 || o_if_rdata !== 0 || o_ex_rdata !== 0) begin
            n_err++;
            $display("FAIL idle_stray: if_rsp=%b ex_rsp=%b bus_val=%b, required all 0",
                     o_if_rsp_val, o_ex_rsp_val, o_bus_val);
        end
        step();
        i_bus_rsp_val = 0;
        issue(0, 1, 32'h0, 32'h600, 32'h0, 1, 0, 1, 32'h0BAD_F00D, 0, 0);
        run_bus(2, 1);
    endtask

    task automatic test_reset_in_rsp();
        issue(0, 1, 32'h0, 32'h500, 32'h0, 1, 0, 1, 32'h99, 0, 0);
        sb.delete();
        i_bus_rdy = 1;
        step();
        i_bus_rdy = 0;
        rst_n = 0;
        #1;
        n_vec++;
        if ((o_if_rsp_val | o_ex_rsp_val | o_bus_val | o_arb4if_rdy | hs_mem4ex_rdy) !== 1'b0) begin
            n_err++;
            $display("FAIL rsp_reset: rsp=%b%b bus_val=%b rdy=%b%b, required all 0",
                     o_if_rsp_val, o_ex_rsp_val, o_bus_val, o_arb4if_rdy, hs_mem4ex_rdy);
        end
        step();
        rst_n = 1;
        step();
        step();
        i_bus_rsp_val = 1; i_bus_rdata = 32'h99;
        #1;
        n_vec++;
        if ((o_if_rsp_val | o_ex_rsp_val | o_bus_val) !== 1'b0 || o_ex_rdata !== 0) begin
            n_err++;
            $display("FAIL stale_rsp: if_rsp=%b ex_rsp=%b bus_val=%b ex_rd=%h, required all 0",
                     o_if_rsp_val, o_ex_rsp_val, o_bus_val, o_ex_rdata);
        end
        hs_ex4mem_val = 1;
        #1;
        n_vec++;
        if (hs_mem4ex_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset: ex_rdy=%b, required 1", hs_mem4ex_rdy);
        end
        hs_ex4mem_val = 0;
        i_bus_rsp_val = 0;
        step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_ex_read();
        test_arb_order();
        test_starve();
        test_write_stall();
        test_no_strobe();
        test_stray_rsp();
        test_reset_in_rsp();
        test_ex_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
